// File: rtl/keypad_encoder.sv
// Scans a 4x4 active-low keypad plus three direct memory buttons, debounces each
// group per frame and emits one-clock key strobes for the calculator control block.
module keypad_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] col_in,
  input  logic [2:0] mem_n,
  output logic [3:0] row_out,
  output logic [3:0] digit,
  output logic [1:0] op_code,
  output logic       dig_in,
  output logic       op_in,
  output logic       sub_in,
  output logic       ex_in,
  output logic       bksp_in,
  output logic       reset_in,
  output logic       MS_in,
  output logic       MR_in,
  output logic       MC_in
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0] col_s1_q, col_s2_q;
  logic [2:0] mem_s1_q, mem_s2_q;
  logic             scan_en_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_q;
  logic [1:0]       acc_n_q;
  logic [3:0]       acc_code_q;
  logic [3:0]       m_prev_code_q, m_prev_code_d;
  logic             m_prev_valid_q, m_prev_valid_d, m_latched_q, m_latched_d, m_fire;
  logic [CNT_W-1:0] m_cnt_q, m_cnt_d, m_none_q, m_none_d;
  logic [2:0]       k_prev_q, k_prev_d;
  logic             k_prev_valid_q, k_prev_valid_d, k_latched_q, k_latched_d, k_fire;
  logic [CNT_W-1:0] k_cnt_q, k_cnt_d, k_none_q, k_none_d;
  logic [2:0]       mem_pend_q;
  logic dig_q, op_q, sub_q, ex_q, bksp_q, rst_q, ms_q, mr_q, mc_q;
  logic [3:0] digit_q;
  logic [1:0] op_code_q;

  logic       slot_end, frame_end, f_valid, k_valid;
  logic [3:0] row_low, tot_code, dig_val;
  logic [2:0] row_cnt, mem_low;
  logic [1:0] row_col, tot_n;

  assign row_out   = scan_en_q ? ~(4'b0001 << row_q) : 4'b1111;
  assign slot_end  = scan_en_q && (div_q == DIV_LAST);
  assign frame_end = slot_end && (row_q == 2'd3);
  assign row_low   = ~col_s2_q;
  assign row_cnt   = {2'b00, row_low[0]} + {2'b00, row_low[1]} + {2'b00, row_low[2]} + {2'b00, row_low[3]};

  // Per-frame key tally: 0, 1 or "2 or more" keys seen; code kept only for the single-key case.
  always_comb begin
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) if (row_low[c]) row_col = 2'(c);
    tot_n    = acc_n_q;
    tot_code = acc_code_q;
    if (row_cnt >= 3'd2) tot_n = 2'd2;
    else if (row_cnt == 3'd1) begin
      if (acc_n_q == 2'd0) begin
        tot_n    = 2'd1;
        tot_code = {row_q, row_col};
      end else begin
        tot_n = 2'd2;
      end
    end
  end

  assign f_valid = frame_end && (tot_n == 2'd1);
  assign mem_low = ~mem_s2_q;
  assign k_valid = frame_end && (mem_low == 3'b001 || mem_low == 3'b010 || mem_low == 3'b100);
  assign dig_val = {2'b00, tot_code[3:2]} * 4'd3 + {2'b00, tot_code[1:0]} + 4'd1;

  always_comb begin
    m_cnt_d = m_cnt_q; m_none_d = m_none_q; m_latched_d = m_latched_q;
    m_prev_code_d = m_prev_code_q; m_prev_valid_d = m_prev_valid_q; m_fire = 1'b0;
    if (frame_end) begin
      if (f_valid) begin
        m_none_d = '0;
        if (m_prev_valid_q && tot_code == m_prev_code_q)
          m_cnt_d = (m_cnt_q == CNT_MAX) ? m_cnt_q : m_cnt_q + 1'b1;
        else
          m_cnt_d = CNT_W'(1);
        if (m_cnt_d == CNT_MAX && !m_latched_q) begin
          m_fire      = 1'b1;
          m_latched_d = 1'b1;
        end
      end else begin
        m_cnt_d  = '0;
        m_none_d = (m_none_q == CNT_MAX) ? m_none_q : m_none_q + 1'b1;
        if (m_none_d == CNT_MAX) m_latched_d = 1'b0;
      end
      m_prev_valid_d = f_valid;
      m_prev_code_d  = tot_code;
    end
  end

  always_comb begin
    k_cnt_d = k_cnt_q; k_none_d = k_none_q; k_latched_d = k_latched_q;
    k_prev_d = k_prev_q; k_prev_valid_d = k_prev_valid_q; k_fire = 1'b0;
    if (frame_end) begin
      if (k_valid) begin
        k_none_d = '0;
        if (k_prev_valid_q && mem_low == k_prev_q)
          k_cnt_d = (k_cnt_q == CNT_MAX) ? k_cnt_q : k_cnt_q + 1'b1;
        else
          k_cnt_d = CNT_W'(1);
        if (k_cnt_d == CNT_MAX && !k_latched_q) begin
          k_fire      = 1'b1;
          k_latched_d = 1'b1;
        end
      end else begin
        k_cnt_d  = '0;
        k_none_d = (k_none_q == CNT_MAX) ? k_none_q : k_none_q + 1'b1;
        if (k_none_d == CNT_MAX) k_latched_d = 1'b0;
      end
      k_prev_valid_d = k_valid;
      k_prev_d       = mem_low;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_s1_q <= 4'hF; col_s2_q <= 4'hF; mem_s1_q <= 3'h7; mem_s2_q <= 3'h7;
      scan_en_q <= 1'b0; div_q <= '0; row_q <= 2'd0;
      acc_n_q <= 2'd0; acc_code_q <= 4'd0;
      m_prev_code_q <= 4'd0; m_prev_valid_q <= 1'b0; m_latched_q <= 1'b0;
      m_cnt_q <= '0; m_none_q <= '0;
      k_prev_q <= 3'd0; k_prev_valid_q <= 1'b0; k_latched_q <= 1'b0;
      k_cnt_q <= '0; k_none_q <= '0;
      mem_pend_q <= 3'd0;
      dig_q <= 1'b0; op_q <= 1'b0; sub_q <= 1'b0; ex_q <= 1'b0; bksp_q <= 1'b0; rst_q <= 1'b0;
      ms_q <= 1'b0; mr_q <= 1'b0; mc_q <= 1'b0;
      digit_q <= 4'd0; op_code_q <= 2'd0;
    end else begin
      col_s1_q <= col_in;  col_s2_q <= col_s1_q;
      mem_s1_q <= mem_n;   mem_s2_q <= mem_s1_q;
      scan_en_q <= 1'b1;
      if (scan_en_q) begin
        if (div_q == DIV_LAST) begin
          div_q <= '0;
          row_q <= row_q + 2'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
      if (slot_end) begin
        acc_n_q    <= frame_end ? 2'd0 : tot_n;
        acc_code_q <= frame_end ? 4'd0 : tot_code;
      end
      m_prev_code_q <= m_prev_code_d; m_prev_valid_q <= m_prev_valid_d; m_latched_q <= m_latched_d;
      m_cnt_q <= m_cnt_d; m_none_q <= m_none_d;
      k_prev_q <= k_prev_d; k_prev_valid_q <= k_prev_valid_d; k_latched_q <= k_latched_d;
      k_cnt_q <= k_cnt_d; k_none_q <= k_none_d;

      dig_q <= 1'b0; op_q <= 1'b0; sub_q <= 1'b0; ex_q <= 1'b0; bksp_q <= 1'b0; rst_q <= 1'b0;
      if (m_fire) begin
        if (tot_code[1:0] == 2'd3) begin
          case (tot_code[3:2])
            2'd0:    begin op_q <= 1'b1; op_code_q <= 2'b00; end
            2'd1:    begin op_q <= 1'b1; sub_q <= 1'b1; op_code_q <= 2'b01; end
            2'd2:    ex_q <= 1'b1;
            default: bksp_q <= 1'b1;
          endcase
        end else if (tot_code[3:2] == 2'd3) begin
          case (tot_code[1:0])
            2'd0:    rst_q <= 1'b1;
            2'd1:    begin dig_q <= 1'b1; digit_q <= 4'd0; end
            default: begin op_q <= 1'b1; op_code_q <= 2'b10; end
          endcase
        end else begin
          dig_q   <= 1'b1;
          digit_q <= dig_val;
        end
      end

      // A memory event colliding with a matrix event is deferred one cycle, never dropped.
      {ms_q, mr_q, mc_q} <= {mem_pend_q[0], mem_pend_q[1], mem_pend_q[2]};
      mem_pend_q <= 3'd0;
      if (k_fire) begin
        if (m_fire) mem_pend_q <= mem_low;
        else {ms_q, mr_q, mc_q} <= {mem_low[0], mem_low[1], mem_low[2]};
      end
    end
  end

  assign digit    = digit_q;
  assign op_code  = op_code_q;
  assign dig_in   = dig_q;
  assign op_in    = op_q;
  assign sub_in   = sub_q;
  assign ex_in    = ex_q;
  assign bksp_in  = bksp_q;
  assign reset_in = rst_q;
  assign MS_in    = ms_q;
  assign MR_in    = mr_q;
  assign MC_in    = mc_q;
endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: a keypad model drives the columns, a monitor logs strobes,
// and an event-level reference model built from the key map supplies the expected stream.
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int LAT_MAX  = 2 + FRAME + DEB * FRAME + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] col_in;
  logic [2:0] mem_n;
  logic [3:0] row_out, digit;
  logic [1:0] op_code;
  logic dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in;

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clock(clock), .reset_n(reset_n), .col_in(col_in), .mem_n(mem_n),
    .row_out(row_out), .digit(digit), .op_code(op_code),
    .dig_in(dig_in), .op_in(op_in), .sub_in(sub_in), .ex_in(ex_in), .bksp_in(bksp_in),
    .reset_in(reset_in), .MS_in(MS_in), .MR_in(MR_in), .MC_in(MC_in)
  );

  // clock / reset
  always #5 clock = ~clock;

  // keypad model: a pressed key shorts its column to the driven row
  logic [15:0] pressed = 16'h0;
  logic [2:0]  mem_press = 3'b000;
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !row_out[r]) col_in[c] = 1'b0;
    mem_n = ~mem_press;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // monitor: {dig,op,sub,ex,bksp,reset,MS,MR,MC, digit, op_code}
  logic [14:0] obs_q[$];
  int          obs_cyc[$];
  logic [14:0] exp_q[$];
  wire  [8:0]  strobes = {dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in};
  always @(negedge clock)
    if (reset_n && strobes != 9'd0) begin
      obs_q.push_back({strobes, digit, op_code});
      obs_cyc.push_back(cyc);
    end

  // scoreboard
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  // reference model: event per key character, digit/op_code held between events
  string      keymap = "123A456B789C*0#D";
  logic [3:0] m_digit = 4'd0;
  logic [1:0] m_op = 2'd0;

  task automatic model_key(input int code);
    byte        ch;
    logic [8:0] s;
    ch = keymap[code];
    s  = 9'd0;
    if (ch >= "0" && ch <= "9") begin s[8] = 1'b1; m_digit = 4'(ch - "0"); end
    else if (ch == "A") begin s[7] = 1'b1; m_op = 2'b00; end
    else if (ch == "B") begin s[7] = 1'b1; s[6] = 1'b1; m_op = 2'b01; end
    else if (ch == "#") begin s[7] = 1'b1; m_op = 2'b10; end
    else if (ch == "C") s[5] = 1'b1;
    else if (ch == "D") s[4] = 1'b1;
    else s[3] = 1'b1;
    exp_q.push_back({s, m_digit, m_op});
  endtask

  task automatic model_mem(input int i);
    logic [2:0] hot;
    hot = 3'b100 >> i;
    exp_q.push_back({6'd0, hot, m_digit, m_op});
  endtask

  // driver helpers
  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(negedge clock);
  endtask

  task automatic wait_frame_start();
    logic [3:0] prev;
    bit         ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME && !ok; i++) begin
      prev = row_out;
      @(negedge clock);
      if (prev == 4'b0111 && row_out == 4'b1110) ok = 1'b1;
    end
    check("frame_align", ok, 1);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      #1;
      if (obs_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic press_key(input int code, input int hold);
    pressed[code] = 1'b1;
    model_key(code);
    wait_frames(hold);
    pressed[code] = 1'b0;
    wait_frames(6);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_row"}, row_out, 4'b1111);
    check({tag, "_strb"}, strobes, 9'd0);
    check({tag, "_digit"}, digit, 4'd0);
    check({tag, "_op"}, op_code, 2'd0);
  endtask

  initial begin
    bit ok;
    int t0, lat;
    #2;
    check_cleared("reset");
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("first_row", row_out, 4'b1110);

    // key 5 with latency bound
    repeat ($urandom_range(0, FRAME - 1)) @(negedge clock);
    t0 = cyc;
    pressed[5] = 1'b1;
    model_key(5);
    wait_obs(1, LAT_MAX + 10, ok);
    check("k5_seen", ok, 1);
    lat = ok ? obs_cyc[0] - t0 : 0;
    check("k5_lat_max", lat <= LAT_MAX, 1);
    check("k5_lat_min", lat >= (DEB - 1) * FRAME, 1);
    wait_frames(9);
    pressed[5] = 1'b0;
    wait_frames(6);
    compare_q("k5");

    // B then #
    press_key(7, 6);
    compare_q("kB");
    press_key(14, 6);
    compare_q("kHash");

    // bouncing key 3 on press and release
    model_key(2);
    for (int i = 0; i < 7; i++) begin pressed[2] = ~pressed[2]; repeat (5) @(negedge clock); end
    pressed[2] = 1'b1;
    wait_frames(6);
    for (int i = 0; i < 7; i++) begin pressed[2] = ~pressed[2]; repeat (5) @(negedge clock); end
    pressed[2] = 1'b0;
    wait_frames(5);
    compare_q("k3_bounce");
    press_key(2, 6);
    compare_q("k3_repress");

    // ghost rejection: 1 and 9 together, then 9 released
    wait_frame_start();
    pressed[0] = 1'b1; pressed[10] = 1'b1;
    wait_frames(6);
    compare_q("ghost");
    pressed[10] = 1'b0;
    model_key(0);
    wait_frames(6);
    pressed[0] = 1'b0;
    wait_frames(6);
    compare_q("ghost_release");

    // D and MR on the same frame end
    wait_frame_start();
    pressed[15] = 1'b1; mem_press[1] = 1'b1;
    model_key(15); model_mem(1);
    wait_frames(6);
    pressed[15] = 1'b0; mem_press[1] = 1'b0;
    wait_frames(6);
    if (obs_cyc.size() >= 2) check("mr_delay", obs_cyc[1] - obs_cyc[0], 1);
    else check("mr_both_seen", obs_cyc.size(), 2);
    compare_q("d_mr");

    // randomized key presses
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, FRAME - 1)) @(negedge clock);
      press_key($urandom_range(0, 15), $urandom_range(5, 8));
    end
    compare_q("random");

    // reset while 7 held and an MS strobe pending
    wait_frame_start();
    pressed[8] = 1'b1; mem_press[0] = 1'b1;
    model_key(8);
    wait_obs(1, 6 * FRAME, ok);
    check("k7_pre_seen", ok, 1);
    reset_n = 1'b0;
    mem_press = 3'b000;
    #1;
    check_cleared("mid_reset");
    m_digit = 4'd0; m_op = 2'd0;
    repeat (3) @(negedge clock);
    compare_q("k7_pre");
    reset_n = 1'b1;
    t0 = cyc;
    model_key(8);
    wait_obs(1, LAT_MAX + 10, ok);
    check("k7_post_seen", ok, 1);
    lat = ok ? obs_cyc[0] - t0 : 0;
    check("k7_lat_max", lat <= LAT_MAX, 1);
    check("k7_lat_min", lat >= (DEB - 1) * FRAME, 1);
    wait_frames(6);
    pressed[8] = 1'b0;
    wait_frames(6);
    compare_q("k7_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Front end for the calculator control FSM: scans a 4x4 active-low matrix keypad and three direct memory buttons, synchronises and debounces them, and emits one-clock key-event strobes.
- Outputs drive the control block directly: dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in.
- Also supplies the digit value and operator code for the datapath.

Parameters:
SCAN_DIV, 1000, clock cycles each row is driven per scan slot (>=2)
DEBOUNCE_FRAMES, 4, consecutive identical frames required for press or release (>=1)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
col_in  input  4  keypad columns, active-low, pulled up, asynchronous
mem_n  input  3  direct buttons, active-low, asynchronous: [0]=MS, [1]=MR, [2]=MC
row_out  output  4  keypad row drive, active-low, one-hot-zero
digit  output  4  digit value 0-9; valid while dig_in is high, held afterwards
op_code  output  2  operator code (00 add, 01 subtract, 10 multiply); valid with op_in, held afterwards
dig_in, op_in, sub_in, ex_in, bksp_in, reset_in  output  1 each  one-cycle key strobes
MS_in, MR_in, MC_in  output  1 each  one-cycle memory strobes

Behaviour:
- Reset (async, reset_n=0): row_out=4'b1111, all strobes 0, digit=0, op_code=0, scan counters 0, debounce state cleared, latched flags cleared.
- First cycle after reset release: row_out=4'b1110 (row 0).
- Synchronisation: col_in and mem_n each pass through a 2-flop synchroniser before any use.
- Scan:
  - Row r (0..3) is driven low for SCAN_DIV cycles; row_out = ~(1<<r).
  - Synchronised columns are sampled on the last cycle of each row slot.
  - A frame is 4*SCAN_DIV cycles and wraps from row 3 back to row 0.
- Frame result:
  - Exactly one matrix key low gives a valid code = 4*r + c.
  - Zero keys gives "none". Two or more keys also gives "none" (ghost rejection).
  - The memory group is evaluated in the same frame: exactly one of mem_n low is valid, otherwise none.
- Key map (row: col0..col3):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- Debounce, per group (matrix and memory independent), evaluated at frame end:
  - Same valid code as the previous frame: increment the stable count (saturating). Otherwise the count restarts at 1 for the new code, or 0 for none.
  - Press: count reaches DEBOUNCE_FRAMES and the group is not latched -> emit the event, set latched.
  - Release: DEBOUNCE_FRAMES consecutive none-frames -> clear latched.
  - While latched, no further events, including for a different key or a held key (no auto-repeat).
- Event emission:
  - Matrix strobes assert in the cycle after the frame-end sample, for exactly 1 cycle.
  - Digit keys: dig_in=1 and digit = key value in the same cycle.
  - A: op_in=1, op_code=00.
  - #: op_in=1, op_code=10.
  - B: sub_in=1 and op_in=1 together, op_code=01 (serves as both unary minus and binary subtract).
  - C: ex_in. D: bksp_in. *: reset_in.
- Simultaneous events: if matrix and memory events fire on the same frame end, the matrix strobe is emitted at t+1 and the memory strobe at t+2 via a pending flag. A strobe is never dropped.
- Latency, key press to strobe: 2 sync cycles + up to 1 frame of scan alignment + DEBOUNCE_FRAMES frames + 1 cycle.
- Reset mid-operation: the asynchronous clear aborts any pending strobe. A key held through reset must re-debounce after release of reset and then produces exactly one event.
- Counter widths: $clog2 of the parameter bounds. No arithmetic overflow is allowed (the stable count saturates).

Test Plan:
- SCAN_DIV=4, DEBOUNCE_FRAMES=3, press key "5" (col1 low while row1 driven), held 10 frames -> exactly one dig_in pulse with digit=5, within 2+16+48+1 cycles; no other strobes.
- Press B -> one cycle with sub_in=1, op_in=1, op_code=01. Release, then press # -> op_in=1, op_code=10, sub_in=0.
- Key "3" bouncing (toggling every 5 cycles for 2 frames) then stable -> single dig_in, digit=3. Release bouncing then stable for 3 frames, then re-press -> second pulse.
- Keys "1" and "9" held together -> no strobes. Release "9" -> dig_in with digit=1 after 3 stable frames.
- mem_n[1] and matrix "D" pressed on the same frame -> bksp_in at t+1, MR_in at t+2, each 1 cycle.
- Assert reset_n=0 while "7" is held and a strobe is pending -> outputs cleared immediately, row_out=1111, no strobe. Deassert with "7" still held -> exactly one dig_in, digit=7, after re-debounce.
